// File: rtl/iq_coef_pkg.sv
// Shared definitions for the IQ correction coefficient sequencer:
// write-address map, FSM encoding and the identity reset values.
package iq_coef_pkg;

    localparam logic [2:0] ADDR_AMAT11  = 3'd0;
    localparam logic [2:0] ADDR_AMAT21  = 3'd1;
    localparam logic [2:0] ADDR_AMAT12  = 3'd2;
    localparam logic [2:0] ADDR_AMAT22  = 3'd3;
    localparam logic [2:0] ADDR_BVECT1  = 3'd4;
    localparam logic [2:0] ADDR_BVECT2  = 3'd5;
    localparam logic [2:0] ADDR_RSVD    = 3'd6;
    localparam logic [2:0] ADDR_ERR_CLR = 3'd7;

    localparam int NUM_AMAT  = 4;
    localparam int NUM_BVECT = 2;
    localparam int TIMER_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Identity transform: unity on the matrix diagonal, zero elsewhere.
    function automatic longint unsigned identity_value(input logic [2:0] addr,
                                                       input int unsigned frac);
        if (addr == ADDR_AMAT11 || addr == ADDR_AMAT22)
            return 64'd1 << frac;
        return 64'd0;
    endfunction

endpackage

// File: rtl/iq_settle_timer.sv
// Down-counter that measures the datapath flush after a coefficient update.
// done is high whenever the count has reached zero.
module iq_settle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         count,
    output logic         done
);

    logic [W-1:0] count_reg, count_next;

    always_comb begin
        count_next = count_reg;
        if (load)
            count_next = load_value;
        else if (count && count_reg != '0)
            count_next = count_reg - W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_reg <= '0;
        else
            count_reg <= count_next;
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/iq_coef_sequencer.sv
// Double-buffered IQ correction coefficients with atomic commit and settle timing.
// Optional readback port enabled by defining IQ_COEF_READBACK_EN.
module iq_coef_sequencer
    import iq_coef_pkg::*;
#(
    parameter int INPUT_WIDTH     = 14,
    parameter int GAIN_WIDTH      = 24,
    parameter int GAIN_WIDTH_FRAC = 12,
    parameter int SETTLE_CYCLES   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [2:0]             wr_addr,
    input  logic [GAIN_WIDTH-1:0]  wr_data,
    input  logic                   commit,
    output logic [GAIN_WIDTH-1:0]  Amat11,
    output logic [GAIN_WIDTH-1:0]  Amat21,
    output logic [GAIN_WIDTH-1:0]  Amat12,
    output logic [GAIN_WIDTH-1:0]  Amat22,
    output logic [INPUT_WIDTH-1:0] Bvect1,
    output logic [INPUT_WIDTH-1:0] Bvect2,
    output logic                   settling,
    output logic                   err
`ifdef IQ_COEF_READBACK_EN
    ,
    input  logic [2:0]             rd_addr,
    output logic [GAIN_WIDTH-1:0]  rd_data
`endif
);

    state_t state_reg, state_next;
    logic   pending_reg, pending_next;
    logic   settling_reg;
    logic   err_reg;
    logic   wr_fire;
    logic   apply;
    logic   timer_load, timer_count, timer_done;

    logic [GAIN_WIDTH-1:0]  amat_active  [NUM_AMAT];
    logic [INPUT_WIDTH-1:0] bvect_active [NUM_BVECT];

    assign wr_ready = (state_reg == ST_IDLE);
    assign wr_fire  = wr_valid && wr_ready;

    // Writes are only accepted in IDLE, so the shadow set is stable during APPLY.
    for (genvar gi = 0; gi < NUM_AMAT; gi++) begin : g_amat
        localparam logic [GAIN_WIDTH-1:0] RESET_VAL =
            GAIN_WIDTH'(identity_value(3'(gi), GAIN_WIDTH_FRAC));
        logic [GAIN_WIDTH-1:0] shadow_reg, active_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow_reg <= RESET_VAL;
                active_reg <= RESET_VAL;
            end else begin
                if (wr_fire && wr_addr == 3'(gi))
                    shadow_reg <= wr_data;
                if (apply)
                    active_reg <= shadow_reg;
            end
        end
        assign amat_active[gi] = active_reg;
    end

    for (genvar gi = 0; gi < NUM_BVECT; gi++) begin : g_bvect
        localparam logic [INPUT_WIDTH-1:0] RESET_VAL =
            INPUT_WIDTH'(identity_value(ADDR_BVECT1 + 3'(gi), GAIN_WIDTH_FRAC));
        logic [INPUT_WIDTH-1:0] shadow_reg, active_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow_reg <= RESET_VAL;
                active_reg <= RESET_VAL;
            end else begin
                if (wr_fire && wr_addr == ADDR_BVECT1 + 3'(gi))
                    shadow_reg <= wr_data[INPUT_WIDTH-1:0];
                if (apply)
                    active_reg <= shadow_reg;
            end
        end
        assign bvect_active[gi] = active_reg;
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        apply        = 1'b0;
        timer_load   = 1'b0;
        timer_count  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (commit)
                    state_next = ST_APPLY;
            end
            ST_APPLY: begin
                apply      = 1'b1;
                timer_load = 1'b1;
                state_next = ST_SETTLE;
                if (commit)
                    pending_next = 1'b1;
            end
            ST_SETTLE: begin
                timer_count = 1'b1;
                // A commit on the final settle cycle still counts as pending.
                if (timer_done) begin
                    if (pending_reg || commit) begin
                        state_next   = ST_APPLY;
                        pending_next = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (commit) begin
                    pending_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            pending_reg  <= 1'b0;
            settling_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            settling_reg <= (state_next != ST_IDLE);
            if (wr_fire && wr_addr == ADDR_RSVD)
                err_reg <= 1'b1;
            else if (wr_fire && wr_addr == ADDR_ERR_CLR)
                err_reg <= 1'b0;
        end
    end

    // Loaded on the APPLY edge so SETTLE lasts SETTLE_CYCLES from the active update.
    iq_settle_timer #(
        .W(TIMER_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (TIMER_W'(SETTLE_CYCLES - 1)),
        .count      (timer_count),
        .done       (timer_done)
    );

    assign Amat11   = amat_active[0];
    assign Amat21   = amat_active[1];
    assign Amat12   = amat_active[2];
    assign Amat22   = amat_active[3];
    assign Bvect1   = bvect_active[0];
    assign Bvect2   = bvect_active[1];
    assign settling = settling_reg;
    assign err      = err_reg;

`ifdef IQ_COEF_READBACK_EN
    logic [GAIN_WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else begin
            case (rd_addr)
                ADDR_AMAT11: rd_data_reg <= amat_active[0];
                ADDR_AMAT21: rd_data_reg <= amat_active[1];
                ADDR_AMAT12: rd_data_reg <= amat_active[2];
                ADDR_AMAT22: rd_data_reg <= amat_active[3];
                ADDR_BVECT1: rd_data_reg <= GAIN_WIDTH'($signed(bvect_active[0]));
                ADDR_BVECT2: rd_data_reg <= GAIN_WIDTH'($signed(bvect_active[1]));
                default:     rd_data_reg <= '0;
            endcase
        end
    end

    assign rd_data = rd_data_reg;
`endif

endmodule

// File: doc/iq_coef_sequencer.md
IQ_COEF_SEQUENCER -- requirements
Module: iq_coef_sequencer

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 14, offset (Bvect) width.
REQ-002 SHALL have parameter GAIN_WIDTH, default 24, matrix coefficient width.
REQ-003 SHALL have parameter GAIN_WIDTH_FRAC, default 12, coefficient fractional bits.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 5, correction-datapath flush length, legal range 1..255.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port wr_valid  in  1  coefficient write request.
REQ-008 SHALL have port wr_ready  out  1  write accepted when wr_valid&wr_ready at a rising edge.
REQ-009 SHALL have port wr_addr  in  3  target: 0 Amat11, 1 Amat21, 2 Amat12, 3 Amat22, 4 Bvect1, 5 Bvect2, 6 reserved, 7 error-clear.
REQ-010 SHALL have port wr_data  in  GAIN_WIDTH  write data, Bvect targets use wr_data[INPUT_WIDTH-1:0].
REQ-011 SHALL have port commit  in  1  single-cycle strobe, shadow-to-active transfer request.
REQ-012 SHALL have ports Amat11, Amat21, Amat12, Amat22  out  GAIN_WIDTH each  active coefficients, registered.
REQ-013 SHALL have ports Bvect1, Bvect2  out  INPUT_WIDTH each  active offsets, registered.
REQ-014 SHALL have port settling  out  1  high while the datapath output is invalid after a coefficient change.
REQ-015 SHALL have port err  out  1  sticky flag, reserved-address write.

Function
REQ-016 SHALL hold a shadow register set and an active register set, six entries each; only active drives outputs.
REQ-017 SHALL implement states IDLE, APPLY and SETTLE; wr_ready = 1 only in IDLE.
REQ-018 SHALL, on an accepted write to addr 0..5, update that shadow entry at the same edge; active is untouched.
REQ-019 SHALL, on an accepted write to addr 6, drop the data and set err; on addr 7, clear err, with set-wins if both occur in one cycle (not possible via one port, so no conflict).
REQ-020 SHALL, on commit sampled in IDLE, go to APPLY; in APPLY, copy all six shadow entries to active in one edge, then go to SETTLE.
REQ-021 SHALL treat a write and commit in the same IDLE cycle as write-first: the committed set includes that write.
REQ-022 SHALL remain in SETTLE for exactly SETTLE_CYCLES cycles, counting from the edge that updated active, then return to IDLE.
REQ-023 SHALL drive settling as a registered output: high from the edge entering APPLY until the edge returning to IDLE (SETTLE_CYCLES+1 cycles per commit).
REQ-024 SHALL latch commit seen in APPLY or SETTLE as pending; on SETTLE exit with pending set, go directly to APPLY (settling stays high) and clear pending; multiple pending commits collapse to one.
REQ-025 SHALL change no active output other than through APPLY, so outputs never show a partially updated set.

Reset
REQ-026 SHALL, on rst (also mid-APPLY/SETTLE), asynchronously set shadow and active to identity: Amat11 = Amat22 = 2^GAIN_WIDTH_FRAC, Amat21 = Amat12 = 0, Bvect1 = Bvect2 = 0; state IDLE, pending 0, settling 0, err 0, wr_ready 1 after release.

Configuration
REQ-027 SHALL, with IQ_COEF_READBACK_EN defined, add ports rd_addr (in, 3) and rd_data (out, GAIN_WIDTH, 1-cycle registered): addr 0..5 returns the active entry (Bvect sign-extended), 6..7 return 0; without the macro, these ports and their logic are absent.

Structure
REQ-028 SHALL take address constants, state encoding and the identity-value function from shared package iq_coef_pkg.
REQ-029 SHALL implement the SETTLE down-counter as sub-module iq_settle_timer (load, count, done).

Verification
REQ-030 SHALL cover reset: after rst, Amat11=4096, Amat22=4096, others 0, settling=0, wr_ready=1.
REQ-031 SHALL cover atomic commit: write Amat21=0x000100, Bvect2=-5; outputs unchanged; commit at cycle N gives new values at edge N+2 and settling high exactly 6 cycles.
REQ-032 SHALL cover same-cycle write+commit: Amat12=7 written with commit -> Amat12=7 after APPLY.
REQ-033 SHALL cover commit during SETTLE: commit twice within SETTLE -> one extra APPLY, settling continuous for 12 cycles, wr_ready low throughout.
REQ-034 SHALL cover errors: write addr 6 -> err=1, shadow unchanged; write addr 7 -> err=0.
REQ-035 SHALL cover rst asserted mid-SETTLE: outputs return to identity asynchronously, pending is discarded, and no APPLY occurs after release.
